// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int unsigned DATA_LAST  = FRAME_BITS - 3;
    localparam int unsigned PARITY_IDX = FRAME_BITS - 2;
    localparam int unsigned STOP_IDX   = FRAME_BITS - 1;

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    typedef logic [7:0]           scan_code_t;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and a one-bit-wider occupancy count.
module ps2_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronizers, frame FSM with timeout,
// odd-parity/stop validation and a scan-code FIFO with sticky overflow.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       code_ready,
    input  logic       overflow_clr,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    logic             clk_prev_q;
    logic             fall;
    logic             bit_in;

    state_t           state_q, state_d;
    bit_cnt_t         bit_cnt_q, bit_cnt_d;
    scan_code_t       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    scan_code_t       fifo_rdata;
    logic [CNT_W-1:0] fifo_count;

    // Synchronizers reset high so a released bus never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign fall   = clk_prev_q & ~clk_sync_q[1];
    assign bit_in = dat_sync_q[1];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall && !bit_in) begin
                    state_d   = RECV;
                    bit_cnt_d = bit_cnt_t'(1);
                end
            end
            RECV: begin
                if (fall) begin
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q <= bit_cnt_t'(DATA_LAST)) begin
                        shift_d = {bit_in, shift_q[7:1]};
                    end else if (bit_cnt_q == bit_cnt_t'(PARITY_IDX)) begin
                        parity_d = bit_in;
                    end else begin
                        if ((^shift_q ^ parity_q) && bit_in) push = 1'b1;
                        else                                 frame_err_d = 1'b1;
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    tmo_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign pop = code_valid & code_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr)                      overflow_d = 1'b0;
        if (push && fifo_full && !pop)         overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (shift_q),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst)
        fifo_full |-> (fifo_count == CNT_W'(FIFO_DEPTH)));

    // Memory is not reset, so the head is masked to keep code at zero while empty.
    assign code_valid = ~fifo_empty;
    assign code       = code_valid ? fifo_rdata : '0;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised and directed bench for ps2_rx_fifo against a frame-level queue model.
module tb_ps2_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       code_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       code_valid;
    logic [7:0] code;
    logic       overflow;
    logic       frame_err;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .code_ready   (code_ready),
        .overflow_clr (overflow_clr),
        .code_valid   (code_valid),
        .code         (code),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        bit          d;
    } fall_t;

    fall_t       falls_q[$];
    logic [7:0]  m_q[$];
    bit          bits_q[$];
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;
    int unsigned since = 0;
    int unsigned edge_cnt = 0;

    logic [7:0]  popped[$];
    int unsigned err_cnt = 0;
    int unsigned valid_cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    bit          rand_mode = 1'b0;
    bit          ready_man = 1'b0;
    bit          clr_man = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: each pin fall takes effect three clock edges later.
    always @(posedge clk) begin
        bit         pop, fell, fd, push, err, good, drop;
        logic [7:0] b8, pcode;
        int unsigned ones;
        edge_cnt++;
        if (rst) begin
            falls_q.delete();
            m_q.delete();
            bits_q.delete();
            m_ovf = 1'b0;
            m_err = 1'b0;
            since = 0;
        end else begin
            pop   = (m_q.size() != 0) && code_ready;
            fell  = 1'b0;
            fd    = 1'b1;
            push  = 1'b0;
            err   = 1'b0;
            drop  = 1'b0;
            pcode = '0;
            if (falls_q.size() != 0 && falls_q[0].due == edge_cnt) begin
                fell = 1'b1;
                fd   = falls_q[0].d;
                void'(falls_q.pop_front());
            end
            if (fell) begin
                since = 0;
                if (bits_q.size() == 0) begin
                    if (!fd) bits_q.push_back(1'b0);
                end else begin
                    bits_q.push_back(fd);
                    if (bits_q.size() == 11) begin
                        for (int i = 0; i < 8; i++) b8[i] = bits_q[i+1];
                        ones = $countones(b8) + int'(bits_q[9]);
                        good = (ones % 2 == 1) && bits_q[10];
                        if (good) begin
                            push  = 1'b1;
                            pcode = b8;
                        end else begin
                            err = 1'b1;
                        end
                        bits_q.delete();
                    end
                end
            end else if (bits_q.size() != 0) begin
                since++;
                if (since == TMO) begin
                    err = 1'b1;
                    bits_q.delete();
                    since = 0;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(pcode);
                else drop = 1'b1;
            end
            m_ovf = drop ? 1'b1 : (overflow_clr ? 1'b0 : m_ovf);
            m_err = err;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            chk("code_valid", 32'(code_valid), 32'(m_q.size() != 0));
            if (code_valid && m_q.size() != 0) chk("code", 32'(code), 32'(m_q[0]));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("frame_err", 32'(frame_err), 32'(m_err));
            if (frame_err) err_cnt++;
            if (code_valid) valid_cyc++;
            if (code_valid && code_ready) popped.push_back(code);
        end
    end

    task automatic tick(input bit force_rdy);
        @(negedge clk);
        if (rand_mode) begin
            code_ready   = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 31) == 0);
        end else begin
            code_ready   = force_rdy ? 1'b1 : ready_man;
            overflow_clr = clr_man;
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic send_bit(input bit b, input int unsigned half, input bit pop_here);
        tick(1'b0);
        ps2_data = b;
        for (int unsigned i = 1; i < half; i++) tick(1'b0);
        tick(1'b0);
        ps2_clk = 1'b0;
        falls_q.push_back('{due: edge_cnt + 3, d: b});
        for (int unsigned i = 1; i <= half; i++) tick(pop_here && i == 2);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop,
                              input int unsigned half, input bit pop_at_stop);
        send_bit(1'b0, half, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(c[i], half, 1'b0);
        send_bit(~^c ^ bad_par, half, 1'b0);
        send_bit(~bad_stop, half, pop_at_stop);
        tick(1'b0);
        ps2_data = 1'b1;
        idle(6);
    endtask

    initial begin
        int unsigned base, e0, v0;
        logic [7:0]  exp_codes[9];

        idle(4);
        rst = 1'b0;
        idle(4);
        #1;
        chk("reset_valid", 32'(code_valid), 32'd0);
        chk("reset_code", 32'(code), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);

        // Good 0x1C with consumer ready
        ready_man = 1'b1;
        base = popped.size(); e0 = err_cnt; v0 = valid_cyc;
        send_frame(8'h1C, 1'b0, 1'b0, 8, 1'b0);
        chk("good_count", popped.size(), base + 1);
        if (popped.size() > base) chk("good_code", 32'(popped[base]), 32'h1C);
        chk("good_valid_cycles", valid_cyc - v0, 1);
        chk("good_no_err", err_cnt - e0, 0);

        // Parity error on the same frame
        base = popped.size(); e0 = err_cnt; v0 = valid_cyc;
        send_frame(8'h1C, 1'b1, 1'b0, 8, 1'b0);
        chk("par_err_pulse", err_cnt - e0, 1);
        chk("par_no_valid", valid_cyc - v0, 0);

        // Stop error
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, 6, 1'b0);
        chk("stop_err_pulse", err_cnt - e0, 1);

        // Overflow: nine frames into an eight-deep FIFO
        ready_man = 1'b0;
        for (int unsigned i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 5, 1'b0);
        #1;
        chk("ovf_set", 32'(overflow), 32'd1);
        base = popped.size();
        ready_man = 1'b1;
        idle(12);
        chk("ovf_drain_count", popped.size(), base + 8);
        for (int unsigned i = 0; i < 8; i++)
            if (popped.size() > base + i) chk("ovf_drain_code", 32'(popped[base+i]), i + 1);
        #1;
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_man = 1'b1;
        tick(1'b0);
        clr_man = 1'b0;
        idle(2);
        #1;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with a pop on the stop-bit edge
        ready_man = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            exp_codes[i] = 8'h11 + 8'(i);
            send_frame(exp_codes[i], 1'b0, 1'b0, 5, 1'b0);
        end
        exp_codes[8] = 8'hAA;
        base = popped.size();
        send_frame(8'hAA, 1'b0, 1'b0, 5, 1'b1);
        #1;
        chk("coinc_no_ovf", 32'(overflow), 32'd0);
        ready_man = 1'b1;
        idle(12);
        chk("coinc_count", popped.size(), base + 9);
        for (int unsigned i = 0; i < 9; i++)
            if (popped.size() > base + i) chk("coinc_order", 32'(popped[base+i]), 32'(exp_codes[i]));

        // Timeout on a partial frame, then recovery
        e0 = err_cnt;
        send_bit(1'b0, 6, 1'b0);
        for (int unsigned i = 0; i < 4; i++) send_bit(1'(i), 6, 1'b0);
        ps2_data = 1'b1;
        idle(TMO + 20);
        chk("tmo_err_pulse", err_cnt - e0, 1);
        base = popped.size();
        send_frame(8'hF0, 1'b0, 1'b0, 7, 1'b0);
        chk("tmo_recover_count", popped.size(), base + 1);
        if (popped.size() > base) chk("tmo_recover_code", 32'(popped[base]), 32'hF0);
        chk("tmo_recover_no_err", err_cnt - e0, 1);

        // Reset mid-frame with data buffered
        ready_man = 1'b0;
        send_frame(8'h33, 1'b0, 1'b0, 5, 1'b0);
        #1;
        chk("pre_rst_valid", 32'(code_valid), 32'd1);
        send_bit(1'b0, 5, 1'b0);
        for (int unsigned i = 0; i < 5; i++) send_bit(1'b1, 5, 1'b0);
        idle(4);
        rst = 1'b1;
        idle(3);
        #1;
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        ps2_data = 1'b1;
        idle(4);
        ready_man = 1'b1;
        base = popped.size(); e0 = err_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 6, 1'b0);
        chk("post_rst_count", popped.size(), base + 1);
        if (popped.size() > base) chk("post_rst_code", 32'(popped[base]), 32'h5A);
        chk("post_rst_no_err", err_cnt - e0, 0);

        // Random traffic
        rand_mode = 1'b1;
        for (int unsigned n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                send_bit(1'b0, 5, 1'b0);
                for (int unsigned i = 0; i < $urandom_range(1, 9); i++)
                    send_bit(1'($urandom_range(0, 1)), 5, 1'b0);
                ps2_data = 1'b1;
                idle(TMO + 10);
            end else begin
                send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 7) == 0), $urandom_range(4, 12), 1'b0);
            end
        end
        rand_mode = 1'b0;
        ready_man = 1'b1;
        clr_man = 1'b0;
        idle(20);
        #1;
        chk("final_empty", 32'(code_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
